// File: rtl/filter_frame_ctrl.sv
// filter_frame_ctrl
//   Frame sequencer for the 3x3 low-pass filter datapath. Loads one frame of
//   pixels into the filter over a valid/ready stream, strobes the filter into
//   processing, waits for its finish edge and forwards the filtered raster with
//   valid/last framing. A watchdog flags a filter that never finishes.
//
// Parameters
//   WIDTH, DEPTH  image geometry as counted by the filter
//   TIMEOUT       watchdog limit in PROC cycles (20-bit counter)
//
// Ports
//   clk, rst_n           clock (rising edge) / asynchronous active-low reset
//   start                frame request, sampled only when idle
//   in_pixel, in_valid   upstream pixel stream
//   in_ready             pixel accepted (load phase only)
//   filt_image_input     pixel to filter
//   filt_enable          filter load strobe (one per accepted pixel)
//   filt_enable_process  filter process strobe
//   filt_finish          filter finished (level, sticky)
//   filt_image_output    filtered pixel from filter
//   out_pixel, out_valid, out_last   filtered raster, no backpressure
//   busy, done, error    status: active, frame-complete pulse, sticky timeout
module filter_frame_ctrl #(
  parameter int unsigned WIDTH   = 410,
  parameter int unsigned DEPTH   = 361,
  parameter int unsigned TIMEOUT = 262143
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_pixel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] filt_image_input,
  output logic       filt_enable,
  output logic       filt_enable_process,
  input  logic       filt_finish,
  input  logic [7:0] filt_image_output,
  output logic [7:0] out_pixel,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned FRAME_PIX = (WIDTH - 1) * (DEPTH - 1);
  localparam logic [17:0] PIX_LAST  = 18'(FRAME_PIX - 1);
  localparam logic [19:0] WD_MAX    = 20'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PROC,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [17:0] pix_cnt, pix_cnt_nxt;
  logic [19:0] wd_cnt, wd_cnt_nxt;
  logic        finish_q;
  logic        proc_q;
  logic        done_q;
  logic        error_q, error_nxt;
  logic        hs;
  logic        fin_edge;

  assign hs       = in_valid & (state == S_LOAD);
  // finish_q tracks the input in every state, so a finish level already high
  // when PROC is entered never looks like an edge.
  assign fin_edge = filt_finish & ~finish_q;

  always_comb begin
    state_nxt   = state;
    pix_cnt_nxt = pix_cnt;
    wd_cnt_nxt  = wd_cnt;
    error_nxt   = error_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_LOAD;
          pix_cnt_nxt = '0;
          error_nxt   = 1'b0;
        end
      end
      S_LOAD: begin
        wd_cnt_nxt = '0;
        if (hs) begin
          if (pix_cnt == PIX_LAST) begin
            state_nxt   = S_PROC;
            pix_cnt_nxt = '0;
          end else begin
            pix_cnt_nxt = pix_cnt + 18'd1;
          end
        end
      end
      S_PROC: begin
        // A finish edge wins even on the cycle the watchdog expires.
        if (fin_edge) begin
          state_nxt  = S_DRAIN;
          wd_cnt_nxt = '0;
        end else if (wd_cnt == WD_MAX) begin
          state_nxt  = S_ERR;
          error_nxt  = 1'b1;
          wd_cnt_nxt = '0;
        end else begin
          wd_cnt_nxt = wd_cnt + 20'd1;
        end
      end
      S_DRAIN: begin
        if (pix_cnt == PIX_LAST) begin
          state_nxt   = S_DONE;
          pix_cnt_nxt = '0;
        end else begin
          pix_cnt_nxt = pix_cnt + 18'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pix_cnt  <= '0;
      wd_cnt   <= '0;
      finish_q <= 1'b0;
      proc_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pix_cnt  <= pix_cnt_nxt;
      wd_cnt   <= wd_cnt_nxt;
      finish_q <= filt_finish;
      proc_q   <= (state_nxt == S_PROC);
      done_q   <= (state_nxt == S_DONE);
      error_q  <= error_nxt;
    end
  end

  assign in_ready            = (state == S_LOAD);
  assign filt_enable         = hs;
  assign filt_image_input    = in_ready ? in_pixel : '0;
  assign filt_enable_process = proc_q;
  assign out_valid           = (state == S_DRAIN);
  assign out_pixel           = out_valid ? filt_image_output : '0;
  assign out_last            = out_valid && (pix_cnt == PIX_LAST);
  assign busy                = (state != S_IDLE) && (state != S_ERR);
  assign done                = done_q;
  assign error               = error_q;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Randomized bench for filter_frame_ctrl on a reduced frame geometry. The
// driver plays both the upstream source and the filter, checks handshake and
// status behaviour cycle by cycle, and pushes the expected filtered raster
// into a scoreboard that a separate monitor drains whenever out_valid is seen.
module tb_filter_frame_ctrl;

  localparam int unsigned WIDTH   = 9;
  localparam int unsigned DEPTH   = 7;
  localparam int unsigned TIMEOUT = 60;
  localparam int unsigned FP      = (WIDTH - 1) * (DEPTH - 1);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] in_pixel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] filt_image_input;
  logic       filt_enable;
  logic       filt_enable_process;
  logic       filt_finish;
  logic [7:0] filt_image_output;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       error;

  filter_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .in_pixel            (in_pixel),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .filt_image_input    (filt_image_input),
    .filt_enable         (filt_enable),
    .filt_enable_process (filt_enable_process),
    .filt_finish         (filt_finish),
    .filt_image_output   (filt_image_output),
    .out_pixel           (out_pixel),
    .out_valid           (out_valid),
    .out_last            (out_last),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  typedef struct {
    logic [7:0] pix;
    logic       last;
  } beat_t;

  beat_t       sb[$];
  beat_t       exp_beat;
  int unsigned cmp_cnt  = 0;
  int unsigned fail_cnt = 0;
  int unsigned done_pulses = 0;
  int unsigned good_frames = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {in_ready, filt_image_input, filt_enable, filt_enable_process,
               out_pixel, out_valid, out_last, busy, done, error}, 32'd0);
  endtask

  // Output monitor: pops the scoreboard on every valid beat.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("enable_exclusive", {31'd0, filt_enable & filt_enable_process}, 32'd0);
      if (done) done_pulses++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_beat = sb.pop_front();
          chk("out_pixel", {24'd0, out_pixel}, {24'd0, exp_beat.pix});
          chk("out_last", {31'd0, out_last}, {31'd0, exp_beat.last});
        end
      end else begin
        chk("out_last_idle", {31'd0, out_last}, 32'd0);
      end
    end
  end

  // mode: 0 continuous valid, 1 valid every other cycle, 2 random valid.
  // lat: PROC cycle index on which the filter raises finish.
  task automatic run_frame(input int mode, input int unsigned lat,
                           input bit timeout, input bit finish_high);
    int unsigned base;
    int unsigned k;
    int unsigned cyc;
    int unsigned beats;
    bit          v;
    base        = $urandom_range(0, 255);
    filt_finish = finish_high;
    // Idle cycle carrying the start request.
    start    = 1'b1;
    in_valid = 1'($urandom);
    in_pixel = 8'($urandom);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    chk("idle_filt_enable", {31'd0, filt_enable}, 32'd0);
    step();
    // Load phase.
    k = 0; cyc = 0; beats = 0;
    while (k < FP) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = ($urandom % 3) != 0 || cyc > 20 * FP;
      endcase
      in_valid = v;
      in_pixel = 8'($urandom);
      start    = ($urandom % 8) == 0;
      @(negedge clk);
      chk("load_in_ready", {31'd0, in_ready}, 32'd1);
      chk("load_filt_enable", {31'd0, filt_enable}, {31'd0, v});
      if (v) chk("load_image_input", {24'd0, filt_image_input}, {24'd0, in_pixel});
      chk("load_busy", {31'd0, busy}, 32'd1);
      chk("load_enable_process", {31'd0, filt_enable_process}, 32'd0);
      if (cyc == 0) chk("error_cleared", {31'd0, error}, 32'd0);
      if (filt_enable) beats++;
      if (v) k++;
      cyc++;
      step();
    end
    chk("load_beats", beats, FP);
    in_valid = 1'b0;
    if (timeout) begin
      for (int unsigned c = 0; c <= TIMEOUT; c++) begin
        start = ($urandom % 8) == 0;
        @(negedge clk);
        chk("proc_enable_process", {31'd0, filt_enable_process}, 32'd1);
        chk("proc_busy", {31'd0, busy}, 32'd1);
        chk("proc_error", {31'd0, error}, 32'd0);
        step();
      end
      start = 1'b0;
      @(negedge clk);
      chk("err_error", {31'd0, error}, 32'd1);
      chk("err_busy", {31'd0, busy}, 32'd0);
      chk("err_enable_process", {31'd0, filt_enable_process}, 32'd0);
      step();
      @(negedge clk);
      chk("err_idle_error", {31'd0, error}, 32'd1);
      chk("err_idle_busy", {31'd0, busy}, 32'd0);
      filt_finish = 1'b0;
      step();
    end else begin
      for (int unsigned i = 0; i < FP; i++)
        sb.push_back('{pix: 8'(base + i), last: (i == FP - 1)});
      for (int unsigned c = 0; c <= lat; c++) begin
        start = ($urandom % 8) == 0;
        if (c == lat) filt_finish = 1'b1;
        @(negedge clk);
        chk("proc_enable_process", {31'd0, filt_enable_process}, 32'd1);
        chk("proc_busy", {31'd0, busy}, 32'd1);
        chk("proc_in_ready", {31'd0, in_ready}, 32'd0);
        step();
      end
      for (int unsigned i = 0; i < FP; i++) begin
        filt_image_output = 8'(base + i);
        start = ($urandom % 8) == 0;
        @(negedge clk);
        chk("drain_valid", {31'd0, out_valid}, 32'd1);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        chk("drain_enable_process", {31'd0, filt_enable_process}, 32'd0);
        step();
      end
      start = 1'b1;  // coincides with the final DONE cycle: must be ignored
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("done_out_valid", {31'd0, out_valid}, 32'd0);
      chk("sb_drained", sb.size(), 32'd0);
      step();
      start = 1'b0;
      filt_finish = 1'b0;
      @(negedge clk);
      chk("post_done", {31'd0, done}, 32'd0);
      chk("post_busy", {31'd0, busy}, 32'd0);
      step();
      @(negedge clk);
      chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
      step();
      good_frames++;
    end
  endtask

  task automatic reset_mid_load(input int unsigned at_pix);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int unsigned k = 0; k < at_pix; k++) begin
      in_valid = 1'b1;
      in_pixel = 8'($urandom);
      step();
    end
    @(negedge clk);
    chk("pre_reset_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk_all_zero("reset_immediate_zero");
    @(negedge clk);
    chk_all_zero("reset_hold_zero");
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_release_idle");
    step();
  endtask

  initial begin
    rst_n             = 1'b0;
    start             = 1'b1;
    in_valid          = 1'b1;
    in_pixel          = 8'hA5;
    filt_finish       = 1'b1;
    filt_image_output = 8'h5A;
    #12;
    chk_all_zero("reset_state");
    @(negedge clk);
    chk_all_zero("reset_state_clocked");
    start       = 1'b0;
    in_valid    = 1'b0;
    filt_finish = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_frame(0, 5, 1'b0, 1'b0);
    run_frame(1, 0, 1'b0, 1'b0);
    run_frame(2, TIMEOUT, 1'b0, 1'b0);
    run_frame(0, 0, 1'b1, 1'b0);
    run_frame(2, $urandom_range(1, TIMEOUT - 1), 1'b0, 1'b0);
    run_frame(0, 0, 1'b1, 1'b1);
    run_frame(0, 3, 1'b0, 1'b0);
    reset_mid_load(20);
    run_frame(1, $urandom_range(0, TIMEOUT), 1'b0, 1'b0);
    repeat (3) step();
    chk("done_pulse_count", done_pulses, good_frames);
    chk("sb_final_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit expired");
  end

endmodule
